// File: rtl/dcf77_display_sched_if.sv
// Signal bundle between the dcf77 decoder/board controls and the display scheduler.
// master drives the decoded fields and the user controls; slave is the scheduler.
interface dcf77_display_sched_if;
    logic       frame_valid;
    logic       error;
    logic [6:0] second;
    logic [6:0] minute;
    logic [5:0] hour;
    logic [5:0] day;
    logic [4:0] month;
    logic [7:0] year;
    logic       key_next;
    logic       auto_en;
    logic [6:0] hex3;
    logic [6:0] hex2;
    logic [6:0] hex1;
    logic [6:0] hex0;
    logic [1:0] page;
    logic       synced;

    modport master (
        output frame_valid, error, second, minute, hour, day, month, year,
        output key_next, auto_en,
        input  hex3, hex2, hex1, hex0, page, synced
    );

    modport slave (
        input  frame_valid, error, second, minute, hour, day, month, year,
        input  key_next, auto_en,
        output hex3, hex2, hex1, hex0, page, synced
    );
endinterface

// File: rtl/dcf77_display_sched.sv
// Four-digit 7-segment page scheduler for the dcf77 decoder outputs.
// Pages rotate on a dwell timer or a debounced button; fields are frozen per
// frame; an error blinks "Err " and dashes are shown until the first frame.
module dcf77_display_sched #(
    parameter int CLK_HZ   = 24000000,
    parameter int DWELL_S  = 4,
    parameter int DEBOUNCE = 240000
) (
    input  logic                  clk,
    input  logic                  rst,
    dcf77_display_sched_if.slave  bus
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    localparam logic [1:0] P_HM = 2'd0;
    localparam logic [1:0] P_MS = 2'd1;
    localparam logic [1:0] P_DM = 2'd2;
    localparam logic [1:0] P_YR = 2'd3;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;

    // BCD nibble to active-low segments (bit6 = g); non-decimal nibbles blank
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // 1 Hz prescaler and blink phase
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_reg;
    logic          blink_reg;
    logic          tick1;

    assign tick1 = (presc_reg == PW'(CLK_HZ - 1));

    // Free-running second counter; blink flips once per second
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg <= '0;
            blink_reg <= 1'b0;
        end else if (tick1) begin
            presc_reg <= '0;
            blink_reg <= ~blink_reg;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame snapshot (seconds stay live so they keep ticking)
    // ------------------------------------------------------------------
    logic [6:0] minute_reg;
    logic [5:0] hour_reg;
    logic [5:0] day_reg;
    logic [4:0] month_reg;
    logic [7:0] year_reg;
    logic       synced_reg;

    // Freeze all slow fields together so one page never mixes two frames
    always_ff @(posedge clk) begin
        if (rst) begin
            minute_reg <= '0;
            hour_reg   <= '0;
            day_reg    <= '0;
            month_reg  <= '0;
            year_reg   <= '0;
            synced_reg <= 1'b0;
        end else if (bus.frame_valid) begin
            minute_reg <= bus.minute;
            hour_reg   <= bus.hour;
            day_reg    <= bus.day;
            month_reg  <= bus.month;
            year_reg   <= bus.year;
            synced_reg <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Button debounce: the input must hold one level for DEBOUNCE cycles
    // ------------------------------------------------------------------
    logic [DW-1:0] db_cnt_reg;
    logic          key_last_reg;
    logic          stable_reg;
    logic          press_reg;

    // Restart the stability window on any input change; emit a pulse on
    // an accepted rising edge only
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_reg   <= '0;
            key_last_reg <= 1'b0;
            stable_reg   <= 1'b0;
            press_reg    <= 1'b0;
        end else begin
            press_reg    <= 1'b0;
            key_last_reg <= bus.key_next;
            if (bus.key_next != key_last_reg) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg == DW'(DEBOUNCE - 1)) begin
                if (stable_reg != key_last_reg) begin
                    stable_reg <= key_last_reg;
                    press_reg  <= key_last_reg;
                end
            end else begin
                db_cnt_reg <= db_cnt_reg + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Page FSM with dwell timer
    // ------------------------------------------------------------------
    logic [1:0] page_reg;
    logic [1:0] page_next;
    logic [3:0] dwell_reg;
    logic       expire;
    logic       advance;

    assign expire  = bus.auto_en && tick1 && (dwell_reg == 4'(DWELL_S - 1));
    assign advance = press_reg || expire;

    // Successor page in display order, wrapping back to hours/minutes
    always_comb begin
        page_next = P_HM;
        case (page_reg)
            P_HM:    page_next = P_MS;
            P_MS:    page_next = P_DM;
            P_DM:    page_next = P_YR;
            default: page_next = P_HM;
        endcase
    end

    // A press coinciding with dwell expiry still moves only one page
    always_ff @(posedge clk) begin
        if (rst) begin
            page_reg  <= P_HM;
            dwell_reg <= '0;
        end else if (advance) begin
            page_reg  <= page_next;
            dwell_reg <= '0;
        end else if (!bus.auto_en) begin
            dwell_reg <= '0;
        end else if (tick1) begin
            dwell_reg <= dwell_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Digit map and output selection (index 3 = leftmost digit)
    // ------------------------------------------------------------------
    logic [3:0] nib [4];
    logic [6:0] hex_next [4];
    logic [6:0] hex_reg [4];

    // Pick the four BCD nibbles for the current page
    always_comb begin
        nib[3] = 4'd0;
        nib[2] = 4'd0;
        nib[1] = 4'd0;
        nib[0] = 4'd0;
        case (page_reg)
            P_HM: begin
                nib[3] = {2'b00, hour_reg[5:4]};
                nib[2] = hour_reg[3:0];
                nib[1] = {1'b0, minute_reg[6:4]};
                nib[0] = minute_reg[3:0];
            end
            P_MS: begin
                nib[3] = {1'b0, minute_reg[6:4]};
                nib[2] = minute_reg[3:0];
                nib[1] = {1'b0, bus.second[6:4]};
                nib[0] = bus.second[3:0];
            end
            P_DM: begin
                nib[3] = {2'b00, day_reg[5:4]};
                nib[2] = day_reg[3:0];
                nib[1] = {3'b000, month_reg[4]};
                nib[0] = month_reg[3:0];
            end
            default: begin
                nib[3] = 4'd2;
                nib[2] = 4'd0;
                nib[1] = year_reg[7:4];
                nib[0] = year_reg[3:0];
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            logic [6:0] err_pat;
            if (gi == 3) begin : g_e
                assign err_pat = SEG_E;
            end else if (gi == 0) begin : g_sp
                assign err_pat = SEG_BLANK;
            end else begin : g_r
                assign err_pat = SEG_R;
            end

            // Error overrides everything, then the not-yet-synced dashes
            assign hex_next[gi] = bus.error   ? (blink_reg ? err_pat : SEG_BLANK) :
                                  !synced_reg ? SEG_DASH :
                                                seg7(nib[gi]);
        end
    endgenerate

    // Register the segment drive so all digits switch on the same edge
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                hex_reg[i] <= SEG_DASH;
            end else begin
                hex_reg[i] <= hex_next[i];
            end
        end
    end

    assign bus.hex3   = hex_reg[3];
    assign bus.hex2   = hex_reg[2];
    assign bus.hex1   = hex_reg[1];
    assign bus.hex0   = hex_reg[0];
    assign bus.page   = page_reg;
    assign bus.synced = synced_reg;

endmodule

// File: tb/tb_dcf77_display_sched.sv
// Directed bench for dcf77_display_sched with a 10-cycle "second".
module tb_dcf77_display_sched;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] SR = 7'b0101111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    dcf77_display_sched_if bus ();

    dcf77_display_sched #(
        .CLK_HZ   (10),
        .DWELL_S  (2),
        .DEBOUNCE (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_hex(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                           input logic [6:0] e1, input logic [6:0] e0);
        chk({tag, ".hex3"}, bus.hex3, e3);
        chk({tag, ".hex2"}, bus.hex2, e2);
        chk({tag, ".hex1"}, bus.hex1, e1);
        chk({tag, ".hex0"}, bus.hex0, e0);
        $display("step %s: hex=%b %b %b %b page=%0d synced=%0b",
                 tag, bus.hex3, bus.hex2, bus.hex1, bus.hex0, bus.page, bus.synced);
    endtask

    task automatic press(input int hold);
        bus.key_next = 1'b1;
        step(hold);
        bus.key_next = 1'b0;
        step(12);
    endtask

    task automatic frame();
        bus.frame_valid = 1'b1;
        step(1);
        bus.frame_valid = 1'b0;
    endtask

    initial begin
        logic       err_phase;
        logic       changed;
        logic [6:0] first_h3;

        bus.frame_valid = 1'b0;
        bus.error       = 1'b0;
        bus.second      = 7'h00;
        bus.minute      = 7'h00;
        bus.hour        = 6'h00;
        bus.day         = 6'h00;
        bus.month       = 5'h00;
        bus.year        = 8'h00;
        bus.key_next    = 1'b0;
        bus.auto_en     = 1'b0;

        // Reset and idle: dashes, page 0, not synced
        step(3);
        rst = 1'b0;
        bus.hour   = 6'h13;
        bus.minute = 7'h45;
        step(50);
        chk_hex("idle", SD, SD, SD, SD);
        chk("idle.page", {5'b0, bus.page}, 7'd0);
        chk("idle.synced", {6'b0, bus.synced}, 7'd0);

        // First frame: synced next cycle, digits one cycle later
        bus.frame_valid = 1'b1;
        step(1);
        bus.frame_valid = 1'b0;
        chk("frame.synced", {6'b0, bus.synced}, 7'd1);
        step(1);
        chk_hex("hm1345", S1, S3, S4, S5);

        // Snapshot holds when live fields change without a frame
        bus.hour   = 6'h08;
        bus.minute = 7'h06;
        step(3);
        chk_hex("hold", S1, S3, S4, S5);

        // Auto rotation: 2 ticks -> page 1, 6 more -> wrap to 0
        bus.auto_en = 1'b1;
        step(20);
        chk("auto.page1", {5'b0, bus.page}, 7'd1);
        step(60);
        chk("auto.wrap", {5'b0, bus.page}, 7'd0);
        bus.auto_en = 1'b0;
        step(1);

        // Short glitch ignored, long press advances once
        press(2);
        chk("short.page", {5'b0, bus.page}, 7'd0);
        press(5);
        chk("long.page", {5'b0, bus.page}, 7'd1);

        // Page MS with live seconds
        bus.second = 7'h27;
        step(2);
        chk_hex("ms4527", S4, S5, S2, S7);

        // Error blinks "Err " and blank, 10 cycles per phase
        bus.error = 1'b1;
        step(1);
        first_h3  = bus.hex3;
        err_phase = (first_h3 == SE);
        chk("err.hex0", bus.hex0, SB);
        chk("err.phase_ok", (first_h3 == SE || first_h3 == SB) ? 7'd1 : 7'd0, 7'd1);
        changed = 1'b0;
        for (int i = 0; i < 11 && !changed; i++) begin
            step(1);
            changed = (bus.hex3 != first_h3);
        end
        chk("err.toggle_seen", {6'b0, changed}, 7'd1);
        err_phase = ~err_phase;
        if (err_phase) chk_hex("err.on", SE, SR, SR, SB);
        else           chk_hex("err.off", SB, SB, SB, SB);
        step(10);
        err_phase = ~err_phase;
        if (err_phase) chk_hex("err.on2", SE, SR, SR, SB);
        else           chk_hex("err.off2", SB, SB, SB, SB);
        bus.error = 1'b0;
        step(1);
        chk_hex("err.clear", S4, S5, S2, S7);

        // Date page
        bus.day   = 6'h31;
        bus.month = 5'h12;
        bus.year  = 8'h7A;
        frame();
        press(5);
        chk("dm.page", {5'b0, bus.page}, 7'd2);
        chk_hex("dm3112", S3, S1, S1, S2);

        // Year page: non-decimal nibble blanks
        press(5);
        chk("yr.page", {5'b0, bus.page}, 7'd3);
        chk_hex("yr207A", S2, S0, S7, SB);

        // Manual wrap back to the time page (snapshot now 08:06)
        press(5);
        chk("wrap.page", {5'b0, bus.page}, 7'd0);
        chk_hex("hm0806", S0, S8, S0, S6);

        // Reset mid-operation clears sync, snapshot and page
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_hex("rst", SD, SD, SD, SD);
        chk("rst.page", {5'b0, bus.page}, 7'd0);
        chk("rst.synced", {6'b0, bus.synced}, 7'd0);
        step(2);
        chk_hex("rst.after", SD, SD, SD, SD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
